// File: rtl/tsc_fetch_unit_pkg.sv
// Shared TSC definitions: word size, instruction field positions and fetch state encoding.
// The decoder and the fetch stage both import this package.
package tsc_fetch_unit_pkg;

  localparam int unsigned WORD_SIZE  = 16;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned OPCODE_W   = 4;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;
  localparam int unsigned FUNC_W     = 6;
  localparam int unsigned TARGET_MSB = 11;
  localparam int unsigned TARGET_W   = 12;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StIssue,
    StHalt
  } fetch_state_e;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [WORD_SIZE-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [FUNC_W-1:0] get_func(input logic [WORD_SIZE-1:0] instr);
    return instr[FUNC_MSB:FUNC_LSB];
  endfunction

endpackage

// File: rtl/tsc_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake plus the decode/execute issue handshake.
interface tsc_fetch_unit_if
  import tsc_fetch_unit_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_SIZE
);
  logic                readM;
  logic [WORD_W-1:0]   address;
  logic [WORD_W-1:0]   mem_data;
  logic                inputReady;
  logic [WORD_W-1:0]   instr;
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func_code;
  logic                instr_valid;
  logic                issue_ready;
  logic                jump;
  logic [TARGET_W-1:0] jump_target;
  logic [WORD_W-1:0]   pc;
  logic [WORD_W-1:0]   num_inst;
  logic                fetch_err;

  modport master (
    output readM, address, instr, opcode, func_code, instr_valid, pc, num_inst, fetch_err,
    input  mem_data, inputReady, issue_ready, jump, jump_target
  );

  modport slave (
    input  readM, address, instr, opcode, func_code, instr_valid, pc, num_inst, fetch_err,
    output mem_data, inputReady, issue_ready, jump, jump_target
  );
endinterface

// File: rtl/tsc_next_pc.sv
// Next-PC selection: sequential increment or in-page jump keeping the current upper nibble.
module tsc_next_pc
  import tsc_fetch_unit_pkg::*;
#(
  parameter int unsigned WORD_W = WORD_SIZE
) (
  input  logic [WORD_W-1:0]   pc,
  input  logic                jump,
  input  logic [TARGET_W-1:0] jump_target,
  output logic [WORD_W-1:0]   next_pc
);

  always_comb begin
    if (jump) begin
      next_pc = {pc[WORD_W-1:TARGET_W], jump_target};
    end else begin
      next_pc = pc + 1'b1;
    end
  end

endmodule

// File: rtl/tsc_fetch_unit.sv
// TSC instruction-fetch stage: PC, readM/inputReady memory handshake, instruction latch and
// issue handshake to execute, with a sticky memory-timeout halt.
module tsc_fetch_unit
  import tsc_fetch_unit_pkg::*;
#(
  parameter int unsigned       WORD_W      = WORD_SIZE,
  parameter logic [WORD_W-1:0] RESET_PC    = '0,
  parameter int unsigned       MEM_TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  tsc_fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] num_q, num_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] next_pc;

  tsc_next_pc #(
    .WORD_W (WORD_W)
  ) u_next_pc (
    .pc          (pc_q),
    .jump        (bus.jump),
    .jump_target (bus.jump_target),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // Data arriving on the final permitted cycle still wins over the timeout.
        if (bus.inputReady) begin
          instr_d = bus.mem_data;
          state_d = StIssue;
        end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIssue: begin
        if (bus.issue_ready) begin
          pc_d    = next_pc;
          num_d   = num_q + 1'b1;
          state_d = StReq;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    bus.readM       = (state_q == StReq) || (state_q == StWait);
    bus.instr_valid = (state_q == StIssue);
    bus.address     = pc_q;
    bus.pc          = pc_q;
    bus.instr       = instr_q;
    bus.opcode      = get_opcode(instr_q);
    bus.func_code   = get_func(instr_q);
    bus.num_inst    = num_q;
    bus.fetch_err   = err_q;
  end

endmodule

// File: tb/tb_tsc_fetch_unit.sv
// Randomized bench for tsc_fetch_unit: bench plays memory and execute, and a transaction-level
// model of PC/retire-count/instruction predicts every observed value.
module tb_tsc_fetch_unit;
  import tsc_fetch_unit_pkg::*;

  localparam int unsigned MemTimeout = 4;
  localparam logic [15:0] ResetPc    = 16'h0000;

  logic clk = 1'b0;
  logic reset;
  initial forever #5 clk = ~clk;

  tsc_fetch_unit_if #(.WORD_W(16)) bus ();

  tsc_fetch_unit #(
    .WORD_W      (16),
    .RESET_PC    (ResetPc),
    .MEM_TIMEOUT (MemTimeout)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [15:0] m_pc;
  logic [15:0] m_num;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_req();
    int i = 0;
    while (bus.readM !== 1'b1 && i < 8) begin
      @(negedge clk);
      i++;
    end
    check_val("req_seen", 32'(bus.readM), 32'd1);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.inputReady  = 1'b0;
    bus.issue_ready = 1'b0;
    bus.jump        = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_readM", 32'(bus.readM), 32'd0);
    check_val("rst_valid", 32'(bus.instr_valid), 32'd0);
    check_val("rst_addr", 32'(bus.address), 32'(ResetPc));
    check_val("rst_num", 32'(bus.num_inst), 32'd0);
    check_val("rst_err", 32'(bus.fetch_err), 32'd0);
    check_val("rst_instr", 32'(bus.instr), 32'd0);
    reset = 1'b0;
    m_pc  = ResetPc;
    m_num = '0;
    @(negedge clk);
    check_val("first_readM", 32'(bus.readM), 32'd1);
    check_val("first_addr", 32'(bus.address), 32'(ResetPc));
  endtask

  // One full instruction: memory answers on WAIT cycle k, execute stalls, then retires.
  task automatic fetch_one(input logic [15:0] word, input int k, input int stall,
                           input logic jmp, input logic [11:0] tgt);
    wait_req();
    check_val("req_addr", 32'(bus.address), 32'(m_pc));
    bus.inputReady = 1'($urandom_range(0, 1));
    bus.mem_data   = 16'($urandom);
    for (int i = 1; i <= k; i++) begin
      @(negedge clk);
      check_val("wait_readM", 32'(bus.readM), 32'd1);
      check_val("wait_addr", 32'(bus.address), 32'(m_pc));
      check_val("wait_valid", 32'(bus.instr_valid), 32'd0);
      if (i == k) begin
        bus.inputReady = 1'b1;
        bus.mem_data   = word;
      end else begin
        bus.inputReady = 1'b0;
        bus.mem_data   = 16'($urandom);
      end
    end
    @(negedge clk);
    bus.inputReady = 1'b0;
    bus.mem_data   = 16'($urandom);
    check_val("iss_valid", 32'(bus.instr_valid), 32'd1);
    check_val("iss_readM", 32'(bus.readM), 32'd0);
    check_val("iss_instr", 32'(bus.instr), 32'(word));
    check_val("iss_opcode", 32'(bus.opcode), 32'(word[15:12]));
    check_val("iss_func", 32'(bus.func_code), 32'(word[5:0]));
    check_val("iss_pc", 32'(bus.pc), 32'(m_pc));
    check_val("iss_err", 32'(bus.fetch_err), 32'd0);
    for (int s = 0; s < stall; s++) begin
      bus.issue_ready = 1'b0;
      bus.jump        = 1'($urandom_range(0, 1));
      bus.jump_target = 12'($urandom);
      @(negedge clk);
      check_val("stall_valid", 32'(bus.instr_valid), 32'd1);
      check_val("stall_readM", 32'(bus.readM), 32'd0);
      check_val("stall_instr", 32'(bus.instr), 32'(word));
      check_val("stall_opcode", 32'(bus.opcode), 32'(word[15:12]));
      check_val("stall_pc", 32'(bus.pc), 32'(m_pc));
    end
    bus.issue_ready = 1'b1;
    bus.jump        = jmp;
    bus.jump_target = tgt;
    @(negedge clk);
    bus.issue_ready = 1'b0;
    bus.jump        = 1'b0;
    m_pc  = jmp ? {m_pc[15:12], tgt} : m_pc + 16'd1;
    m_num = m_num + 16'd1;
    check_val("ret_pc", 32'(bus.pc), 32'(m_pc));
    check_val("ret_num", 32'(bus.num_inst), 32'(m_num));
    check_val("ret_readM", 32'(bus.readM), 32'd1);
    check_val("ret_addr", 32'(bus.address), 32'(m_pc));
    check_val("ret_valid", 32'(bus.instr_valid), 32'd0);
  endtask

  task automatic fetch_rand();
    fetch_one(16'($urandom), int'($urandom_range(1, MemTimeout)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 12'($urandom));
  endtask

  // Move the PC into page 'nib' by jumping to the page end and stepping across.
  task automatic walk_to(input logic [3:0] nib);
    int guard = 0;
    while (m_pc[15:12] != nib && guard < 40) begin
      if (m_pc[11:0] != 12'hFFF) fetch_one(16'($urandom), 1, 0, 1'b1, 12'hFFF);
      else fetch_one(16'($urandom), 1, 0, 1'b0, 12'h000);
      guard++;
    end
  endtask

  task automatic timeout_test();
    wait_req();
    bus.inputReady = 1'b0;
    repeat (MemTimeout) begin
      @(negedge clk);
      check_val("to_readM", 32'(bus.readM), 32'd1);
      check_val("to_err_early", 32'(bus.fetch_err), 32'd0);
    end
    @(negedge clk);
    check_val("to_err", 32'(bus.fetch_err), 32'd1);
    check_val("to_readM_off", 32'(bus.readM), 32'd0);
    check_val("to_valid", 32'(bus.instr_valid), 32'd0);
    bus.inputReady  = 1'b1;
    bus.issue_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_val("halt_readM", 32'(bus.readM), 32'd0);
      check_val("halt_valid", 32'(bus.instr_valid), 32'd0);
      check_val("halt_err", 32'(bus.fetch_err), 32'd1);
      check_val("halt_num", 32'(bus.num_inst), 32'(m_num));
    end
    do_reset();
  endtask

  task automatic reset_mid_wait();
    wait_req();
    bus.inputReady = 1'b0;
    @(negedge clk);
    check_val("mw_readM", 32'(bus.readM), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("mw_rst_readM", 32'(bus.readM), 32'd0);
    check_val("mw_rst_valid", 32'(bus.instr_valid), 32'd0);
    reset          = 1'b0;
    bus.inputReady = 1'b1;
    bus.mem_data   = 16'hBEEF;
    m_pc  = ResetPc;
    m_num = '0;
    @(negedge clk);
    bus.inputReady = 1'b0;
    check_val("mw_instr", 32'(bus.instr), 32'd0);
    check_val("mw_valid", 32'(bus.instr_valid), 32'd0);
    check_val("mw_num", 32'(bus.num_inst), 32'd0);
    check_val("mw_readM2", 32'(bus.readM), 32'd1);
    check_val("mw_addr", 32'(bus.address), 32'(ResetPc));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.mem_data    = '0;
    bus.inputReady  = 1'b0;
    bus.issue_ready = 1'b0;
    bus.jump        = 1'b0;
    bus.jump_target = '0;
    do_reset();

    fetch_one(16'h6A05, 1, 0, 1'b0, 12'h000);
    repeat (20) fetch_rand();

    walk_to(4'h3);
    fetch_one(16'($urandom), 2, 0, 1'b1, 12'h004);
    fetch_one(16'h9123, 2, 5, 1'b1, 12'h0A0);
    fetch_rand();

    walk_to(4'hF);
    fetch_one(16'($urandom), 1, 0, 1'b1, 12'hFFF);
    fetch_one(16'($urandom), 1, 0, 1'b0, 12'h000);
    fetch_rand();

    timeout_test();
    fetch_one(16'h4C3F, MemTimeout, 1, 1'b0, 12'h000);
    check_val("exact_to_err", 32'(bus.fetch_err), 32'd0);

    reset_mid_wait();
    repeat (10) fetch_rand();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
